// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encoding, default widths and controller opcodes
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, CAPTURE = 2'd2} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_LDR = 3'b011;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect-over-increment priority and modulo wrap
module fetch_pc_reg #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) pc <= ADDR_W'(RESET_PC);
    else pc <= load ? target : inc ? pc + ADDR_W'(1) : pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning PC/IR and arbitrating the shared memory port
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = 0,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);
  localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic capture_done;
  logic data_own;
  assign capture_done = state == CAPTURE && !pc_load;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  // a redirect always lands in IDLE unless it coincides with a fresh fetch request
  always_comb begin
    next_state = IDLE;
    if (state == IDLE) next_state = fetch_start ? ADDR : IDLE;
    else if (pc_load) next_state = IDLE;
    else if (state == ADDR) next_state = cnt == CNT_LAST ? CAPTURE : ADDR;
  end
  always_comb begin
    data_own = state == IDLE && data_sel;
    busy     = state != IDLE;
    mem_addr = data_own ? data_addr : pc;
    mem_rd   = state == ADDR || (data_own && !data_wr);
    mem_wr   = data_own && data_wr;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      cnt         <= (state == ADDR && !pc_load && cnt != CNT_LAST) ? cnt + CNT_W'(1) : '0;
      instr       <= capture_done ? mem_rdata : instr;
      instr_valid <= capture_done;
    end
  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .load(pc_load),
    .target(pc_target),
    .inc(capture_done),
    .pc(pc)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: two fetch units (MEM_LAT 1 and 3) on shared stimulus vs a countdown reference model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  logic fetch_start, pc_load, data_sel, data_wr;
  logic [7:0] pc_target, data_addr;
  logic [1:0][7:0] maddr, pcv;
  logic [1:0][15:0] instr, rdata;
  logic [1:0] mrd, mwr, ivalid, busy;
  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;
  int lat [2] = '{1, 3};
  logic [7:0] m_pc [2];
  logic [15:0] m_ir [2];
  int m_cnt [2];
  logic m_valid [2];
  logic [7:0] p1a;
  logic p1v;
  logic [2:0][7:0] p3a;
  logic [2:0] p3v;
  int nrd;

  always #5 clk = ~clk;

  instr_fetch_unit #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load), .pc_target(pc_target),
    .data_sel(data_sel), .data_addr(data_addr), .data_wr(data_wr), .mem_addr(maddr[0]),
    .mem_rd(mrd[0]), .mem_wr(mwr[0]), .mem_rdata(rdata[0]), .instr(instr[0]),
    .instr_valid(ivalid[0]), .pc(pcv[0]), .busy(busy[0]));
  instr_fetch_unit #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load), .pc_target(pc_target),
    .data_sel(data_sel), .data_addr(data_addr), .data_wr(data_wr), .mem_addr(maddr[1]),
    .mem_rd(mrd[1]), .mem_wr(mwr[1]), .mem_rdata(rdata[1]), .instr(instr[1]),
    .instr_valid(ivalid[1]), .pc(pcv[1]), .busy(busy[1]));

  // memories return data exactly MEM_LAT edges after a read strobe, garbage otherwise
  always @(posedge clk) begin
    p1a <= maddr[0];
    p1v <= mrd[0];
    p3a <= {p3a[1:0], maddr[1]};
    p3v <= {p3v[1:0], mrd[1]};
  end
  assign rdata[0] = p1v === 1'b1 ? mem[p1a] : 16'hDEAD;
  assign rdata[1] = p3v[2] === 1'b1 ? mem[p3a[2]] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 8'h00;
      m_ir[i] = 16'h0000;
      m_cnt[i] = 0;
      m_valid[i] = 1'b0;
    end
  endtask

  // m_cnt = edges remaining until the instruction lands in IR (0 = idle)
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (pc_load) begin
        m_cnt[i] = (m_cnt[i] == 0 && fetch_start) ? lat[i] + 1 : 0;
        m_pc[i] = pc_target;
      end else if (m_cnt[i] == 0) begin
        if (fetch_start) m_cnt[i] = lat[i] + 1;
      end else begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_ir[i] = mem[m_pc[i]];
          m_pc[i] = m_pc[i] + 8'd1;
          m_valid[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic own;
      own = m_cnt[i] == 0 && data_sel;
      check($sformatf("%s.l%0d.pc", tag, lat[i]), pcv[i], m_pc[i]);
      check($sformatf("%s.l%0d.instr", tag, lat[i]), instr[i], m_ir[i]);
      check($sformatf("%s.l%0d.valid", tag, lat[i]), ivalid[i], m_valid[i]);
      check($sformatf("%s.l%0d.busy", tag, lat[i]), busy[i], m_cnt[i] != 0);
      check($sformatf("%s.l%0d.maddr", tag, lat[i]), maddr[i], own ? data_addr : m_pc[i]);
      check($sformatf("%s.l%0d.mrd", tag, lat[i]), mrd[i], m_cnt[i] > 1 || (own && !data_wr));
      check($sformatf("%s.l%0d.mwr", tag, lat[i]), mwr[i], own && data_wr);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic fetch(input string tag);
    fetch_start = 1'b1;
    step(tag);
    fetch_start = 1'b0;
    repeat (4) step(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    {fetch_start, pc_load, data_sel, data_wr} = '0;
    pc_target = '0;
    data_addr = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 model_reset();
    compare("reset");
    @(posedge clk);
    #3 reset = 1'b1;

    mem[0] = 16'hD105;
    fetch_start = 1'b1;
    step("t1");
    fetch_start = 1'b0;
    step("t1");
    step("t1");
    check("t1_instr", instr[0], 16'hD105);
    check("t1_valid", ivalid[0], 1'b1);
    check("t1_pc", pcv[0], 8'h01);
    repeat (3) step("t1w");
    check("t1_instr_l3", instr[1], 16'hD105);

    pc_load = 1'b1;
    pc_target = 8'hFF;
    step("t2load");
    pc_load = 1'b0;
    mem[8'hFF] = 16'h1111;
    mem[8'h00] = 16'h2222;
    fetch("t2a");
    check("t2_instr_a", instr[0], 16'h1111);
    check("t2_wrap", pcv[0], 8'h00);
    fetch("t2b");
    check("t2_instr_b", instr[1], 16'h2222);
    check("t2_pc", pcv[1], 8'h01);

    fetch_start = 1'b1;
    step("t3");
    fetch_start = 1'b0;
    pc_load = 1'b1;
    pc_target = 8'h20;
    step("t3abort");
    pc_load = 1'b0;
    check("t3_busy", busy[0], 1'b0);
    check("t3_pc", pcv[0], 8'h20);
    check("t3_ir_kept", instr[0], 16'h2222);
    repeat (4) step("t3w");

    data_sel = 1'b1;
    data_addr = 8'h40;
    data_wr = 1'b1;
    step("t4idle");
    check("t4_mwr", mwr[0], 1'b1);
    check("t4_maddr", maddr[0], 8'h40);
    fetch_start = 1'b1;
    step("t4busy");
    fetch_start = 1'b0;
    check("t4_busy_mwr", mwr[0], 1'b0);
    check("t4_busy_maddr", maddr[0], 8'h20);
    repeat (4) step("t4w");
    {data_sel, data_wr} = '0;

    fetch_start = 1'b1;
    step("t5");
    fetch_start = 1'b0;
    step("t5cap");
    #2 reset = 1'b0;
    #1 model_reset();
    compare("t5async");
    check("t5_pc", pcv[0], 8'h00);
    reset = 1'b1;
    step("t5after");

    fetch_start = 1'b1;
    step("t6");
    fetch_start = 1'b0;
    nrd = (mrd[1] && maddr[1] == pcv[1]) ? 1 : 0;
    repeat (4) begin
      step("t6");
      nrd += (mrd[1] && maddr[1] == pcv[1]) ? 1 : 0;
    end
    check("t6_rd_cycles", nrd, 3);

    for (int n = 0; n < 400; n++) begin
      fetch_start = $urandom_range(0, 1) == 1;
      pc_load = $urandom_range(0, 7) == 0;
      pc_target = 8'($urandom);
      data_sel = $urandom_range(0, 1) == 1;
      data_wr = $urandom_range(0, 1) == 1;
      data_addr = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1 model_reset();
        compare("rnd_rst");
        reset = 1'b1;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
